// File: rtl/l1_miss_ctrl.sv
// L1 miss sequencer: accepts CPU loads/stores, runs read/write next-level
// transactions, drives L1 refill/write strobes and keeps hit/miss counters.
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   cpu_*                       CPU request in, rdata/done out, stall_o
//   l1_addr_o, l1_wr_*          L1 lookup address and write strobe/data/byte enables
//   l1_hit_i, l1_rd_data_i      combinational L1 lookup result
//   l1_refill_*                 refill strobe and word (merge base on writes)
//   mem_*                       valid/ack transaction to L2/main memory
//   hit_cnt_o, miss_cnt_o       wrapping lookup counters
module l1_miss_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    input  logic [3:0]            cpu_byte_en_i,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    output logic                  cpu_done_o,
    output logic                  stall_o,
    output logic [ADDR_WIDTH-1:0] l1_addr_o,
    output logic                  l1_wr_en_o,
    output logic [DATA_WIDTH-1:0] l1_wr_data_o,
    output logic [3:0]            l1_byte_en_o,
    input  logic                  l1_hit_i,
    input  logic [DATA_WIDTH-1:0] l1_rd_data_i,
    output logic                  l1_refill_valid_o,
    output logic [DATA_WIDTH-1:0] l1_refill_data_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    output logic [3:0]            mem_byte_en_o,
    input  logic                  mem_ack_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [CNT_WIDTH-1:0]  hit_cnt_o,
    output logic [CNT_WIDTH-1:0]  miss_cnt_o
);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        REFILL,
        WR_REQ,
        L1_WR,
        RESP
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] refill_q;

    // cpu_done_o is high in the IDLE cycle right after RESP; that cycle
    // must not re-accept the still-asserted request.
    assign stall_o      = cpu_req_i & ~cpu_done_o;
    assign l1_addr_o    = (state == IDLE) ? cpu_addr_i : addr_q;
    assign l1_wr_data_o = wdata_q;
    assign l1_byte_en_o = be_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            addr_q            <= '0;
            we_q              <= 1'b0;
            wdata_q           <= '0;
            be_q              <= '0;
            refill_q          <= '0;
            cpu_rdata_o       <= '0;
            cpu_done_o        <= 1'b0;
            l1_wr_en_o        <= 1'b0;
            l1_refill_valid_o <= 1'b0;
            l1_refill_data_o  <= '0;
            mem_req_o         <= 1'b0;
            mem_we_o          <= 1'b0;
            mem_addr_o        <= '0;
            mem_wdata_o       <= '0;
            mem_byte_en_o     <= '0;
            hit_cnt_o         <= '0;
            miss_cnt_o        <= '0;
        end else begin
            cpu_done_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cpu_req_i && !cpu_done_o) begin
                        addr_q   <= cpu_addr_i;
                        we_q     <= cpu_we_i;
                        wdata_q  <= cpu_wdata_i;
                        be_q     <= cpu_byte_en_i;
                        // Merge base for write-hit and full-word paths.
                        refill_q <= l1_rd_data_i;
                        if (l1_hit_i)
                            hit_cnt_o <= hit_cnt_o + CNT_WIDTH'(1);
                        else
                            miss_cnt_o <= miss_cnt_o + CNT_WIDTH'(1);
                        if (!cpu_we_i && l1_hit_i) begin
                            cpu_rdata_o <= l1_rd_data_i;
                            state       <= RESP;
                        end else if (cpu_we_i &&
                                     (l1_hit_i || cpu_byte_en_i == 4'hF)) begin
                            mem_req_o     <= 1'b1;
                            mem_we_o      <= 1'b1;
                            mem_addr_o    <= cpu_addr_i;
                            mem_wdata_o   <= cpu_wdata_i;
                            mem_byte_en_o <= cpu_byte_en_i;
                            state         <= WR_REQ;
                        end else begin
                            // Load miss, or partial store miss that needs
                            // the old word before merging.
                            mem_req_o  <= 1'b1;
                            mem_we_o   <= 1'b0;
                            mem_addr_o <= cpu_addr_i;
                            state      <= RD_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (mem_ack_i) begin
                        mem_req_o         <= 1'b0;
                        refill_q          <= mem_rdata_i;
                        l1_refill_valid_o <= 1'b1;
                        l1_refill_data_o  <= mem_rdata_i;
                        state             <= REFILL;
                    end
                end
                REFILL: begin
                    l1_refill_valid_o <= 1'b0;
                    if (!we_q) begin
                        cpu_rdata_o <= refill_q;
                        state       <= RESP;
                    end else begin
                        mem_req_o     <= 1'b1;
                        mem_we_o      <= 1'b1;
                        mem_addr_o    <= addr_q;
                        mem_wdata_o   <= wdata_q;
                        mem_byte_en_o <= be_q;
                        state         <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (mem_ack_i) begin
                        mem_req_o         <= 1'b0;
                        l1_wr_en_o        <= 1'b1;
                        l1_refill_valid_o <= 1'b1;
                        l1_refill_data_o  <= refill_q;
                        state             <= L1_WR;
                    end
                end
                L1_WR: begin
                    l1_wr_en_o        <= 1'b0;
                    l1_refill_valid_o <= 1'b0;
                    state             <= RESP;
                end
                RESP: begin
                    cpu_done_o <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
